// File: rtl/pulse_meter_pkg.sv
// pulse_meter_pkg: meter FSM state type and the period check shared with the bench
package pulse_meter_pkg;
  typedef enum logic [1:0] {IDLE, MEASURE, TIMEOUT} meter_state_t;
  function automatic bit period_ok(input logic [31:0] actual, input int unsigned t0, input int unsigned t1);
    return actual == 32'(t1 - t0);
  endfunction
endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: synchronizer chain on an asynchronous input plus single-cycle rising-edge pulse
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic pulse_i,
  output logic rise_o
);
  logic [SYNC_STAGES-1:0] sync_r;
  logic prev_r;
  if (SYNC_STAGES < 2) begin : g_bad_stages
    $error("SYNC_STAGES must be at least 2");
  end
  always_ff @(posedge clk)
    if (reset) begin
      sync_r <= '0;
      prev_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], pulse_i};
      prev_r <= sync_r[SYNC_STAGES-1];
    end
  assign rise_o = sync_r[SYNC_STAGES-1] & ~prev_r;
endmodule

// File: rtl/pulse_period_meter.sv
// pulse_period_meter: clk-cycle period between rising edges of pulse_i, with loss-of-signal timeout.
// Define PULSE_METER_MINMAX_EN to track min/max period since reset/clear (otherwise min_o/max_o are 0).
module pulse_period_meter
  import pulse_meter_pkg::meter_state_t, pulse_meter_pkg::IDLE, pulse_meter_pkg::MEASURE;
#(
  parameter int          CNT_WIDTH   = 32,
  parameter int unsigned TIMEOUT     = 100000000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pulse_i,
  input  logic                 clear_i,
  output logic [CNT_WIDTH-1:0] period_o,
  output logic                 period_valid_o,
  output logic                 timeout_o,
  output logic [CNT_WIDTH-1:0] min_o,
  output logic [CNT_WIDTH-1:0] max_o
);
  localparam logic [CNT_WIDTH-1:0] TMO = CNT_WIDTH'(TIMEOUT);
  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);
  meter_state_t state_r;
  logic [CNT_WIDTH-1:0] cnt_r;
  logic rise, take;
  // The counter stops at TIMEOUT, so bounding TIMEOUT rules out any wrap.
  if (TIMEOUT < 2 || 64'(TIMEOUT) >= 64'd1 << CNT_WIDTH) begin : g_bad_timeout
    $error("TIMEOUT must satisfy 2 <= TIMEOUT < 2**CNT_WIDTH");
  end
  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .reset  (reset),
    .pulse_i(pulse_i),
    .rise_o (rise)
  );
  assign take = state_r == MEASURE && rise && !clear_i;
  always_ff @(posedge clk)
    if (reset) begin
      state_r        <= IDLE;
      cnt_r          <= '0;
      period_o       <= '0;
      period_valid_o <= 1'b0;
      timeout_o      <= 1'b0;
    end else begin
      period_valid_o <= take;
      if (clear_i) begin
        state_r   <= IDLE;
        cnt_r     <= '0;
        timeout_o <= 1'b0;
      end else begin
        case (state_r)
          IDLE: if (rise) begin
            state_r <= MEASURE;
            cnt_r   <= ONE;
          end
          MEASURE: if (rise) begin
            period_o <= cnt_r;
            cnt_r    <= ONE;
          end else if (cnt_r == TMO) begin
            state_r   <= pulse_meter_pkg::TIMEOUT;
            timeout_o <= 1'b1;
          end else begin
            cnt_r <= cnt_r + ONE;
          end
          pulse_meter_pkg::TIMEOUT: if (rise) begin
            state_r   <= MEASURE;
            cnt_r     <= ONE;
            timeout_o <= 1'b0;
          end
          default: state_r <= IDLE;
        endcase
      end
    end
`ifdef PULSE_METER_MINMAX_EN
  always_ff @(posedge clk)
    if (reset || clear_i) begin
      min_o <= '1;
      max_o <= '0;
    end else if (take) begin
      min_o <= cnt_r < min_o ? cnt_r : min_o;
      max_o <= cnt_r > max_o ? cnt_r : max_o;
    end
`else
  assign min_o = '0;
  assign max_o = '0;
`endif
endmodule

// File: tb/tb_pulse_period_meter.sv
// tb_pulse_period_meter: scoreboard bench; stimulus queues expected edge-time pairs, monitor checks each strobe
module tb_pulse_period_meter;
  import pulse_meter_pkg::*;
  localparam int W = 32, TMO = 20, S = 2;
`ifdef PULSE_METER_MINMAX_EN
  localparam bit MM = 1'b1;
`else
  localparam bit MM = 1'b0;
`endif
  localparam logic [W-1:0] MIN_RST = MM ? '1 : '0;
  typedef struct {int unsigned t0; int unsigned t1;} exp_t;
  logic clk = 1'b0, reset = 1'b1, pulse_i = 1'b0, clear_i = 1'b0;
  logic [W-1:0] period_o, min_o, max_o;
  logic period_valid_o, timeout_o;
  exp_t exp_q[$];
  exp_t mon_e;
  int tests = 0, fails = 0;
  int unsigned cyc_n = 0, last_t = 0;
  logic prev_v = 1'b0;

  pulse_period_meter #(.CNT_WIDTH(W), .TIMEOUT(TMO), .SYNC_STAGES(S)) dut (
    .clk(clk), .reset(reset), .pulse_i(pulse_i), .clear_i(clear_i),
    .period_o(period_o), .period_valid_o(period_valid_o), .timeout_o(timeout_o),
    .min_o(min_o), .max_o(max_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (period_valid_o) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_valid: got strobe with period %0d, want no strobe", period_o);
      end else begin
        mon_e = exp_q.pop_front();
        if (!period_ok(period_o, mon_e.t0, mon_e.t1)) begin
          fails++;
          $display("FAIL period: got %0d, want %0d", period_o, mon_e.t1 - mon_e.t0);
        end
      end
      tests++;
      if (prev_v) begin
        fails++;
        $display("FAIL valid_back_to_back: got 2 consecutive strobes, want 1");
      end
    end
    prev_v = period_valid_o;
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      cyc_n++;
    end
    #1;
  endtask

  // One-cycle strobe at the current cycle, then idle so the next strobe lands gap cycles later.
  task automatic edge_ev(input bit v, input int gap);
    if (v) exp_q.push_back('{last_t, cyc_n});
    last_t = cyc_n;
    pulse_i = 1'b1;
    cyc(1);
    pulse_i = 1'b0;
    if (gap > 1) cyc(gap - 1);
  endtask

  task automatic drain(input string name);
    cyc(S + 3);
    chk(name, W'(exp_q.size()), '0);
    exp_q.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
  endtask

  initial begin
    cyc(3);
    chk("rst_period", period_o, '0);
    chk("rst_valid", W'(period_valid_o), '0);
    chk("rst_timeout", W'(timeout_o), '0);
    chk("rst_min", min_o, MIN_RST);
    chk("rst_max", max_o, '0);
    reset = 1'b0;
    cyc(2);
    // steady train, first edge is only a reference
    edge_ev(1'b0, 10);
    repeat (3) edge_ev(1'b1, 10);
    edge_ev(1'b1, 1);
    drain("t1_drain");
    chk("t1_min", min_o, MM ? 10 : 0);
    chk("t1_max", max_o, MM ? 10 : 0);
    // mixed spacing for min/max
    do_reset();
    edge_ev(1'b0, 7);
    edge_ev(1'b1, 12);
    edge_ev(1'b1, 5);
    edge_ev(1'b1, 1);
    drain("t2_drain");
    chk("t2_min", min_o, MM ? 5 : 0);
    chk("t2_max", max_o, MM ? 12 : 0);
    // loss of signal and recovery
    do_reset();
    edge_ev(1'b0, 1);
    cyc(S + 19);
    chk("t3_timeout_before", W'(timeout_o), '0);
    cyc(1);
    chk("t3_timeout_set", W'(timeout_o), 1);
    chk("t3_period_held", period_o, '0);
    cyc(10);
    chk("t3_timeout_hold", W'(timeout_o), 1);
    edge_ev(1'b0, 9);
    chk("t3_timeout_clr", W'(timeout_o), '0);
    edge_ev(1'b1, 1);
    drain("t3_drain");
    // edge exactly at the timeout count wins
    do_reset();
    edge_ev(1'b0, TMO);
    edge_ev(1'b1, 3);
    chk("t4_no_timeout", W'(timeout_o), '0);
    drain("t4_drain");
    // clear coincident with an edge
    do_reset();
    edge_ev(1'b0, 8);
    edge_ev(1'b1, 8);
    pulse_i = 1'b1;
    cyc(1);
    pulse_i = 1'b0;
    cyc(S - 1);
    clear_i = 1'b1;
    cyc(1);
    clear_i = 1'b0;
    chk("t5_min_clr", min_o, MIN_RST);
    chk("t5_max_clr", max_o, '0);
    chk("t5_period_held", period_o, 8);
    chk("t5_timeout", W'(timeout_o), '0);
    cyc(5);
    edge_ev(1'b0, 6);
    edge_ev(1'b1, 1);
    drain("t5_drain");
    chk("t5_min", min_o, MM ? 6 : 0);
    // reset mid-period while pulse_i is held high
    pulse_i = 1'b1;
    cyc(2);
    reset = 1'b1;
    cyc(38);
    reset = 1'b0;
    chk("t6_period", period_o, '0);
    chk("t6_timeout", W'(timeout_o), '0);
    chk("t6_min", min_o, MIN_RST);
    chk("t6_max", max_o, '0);
    last_t = cyc_n;
    cyc(10);
    pulse_i = 1'b0;
    cyc(8);
    edge_ev(1'b1, 1);
    drain("t6_drain");
    chk("t6_timeout_end", W'(timeout_o), '0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
